// File: rtl/div_seq_if.sv
// -----------------------------------------------------------------------------
// div_seq_if
// Bundles the request/result handshake of div_seq together with its link to
// the iterative divider div_int.
//   master : the surrounding logic (ALU request side and div_int)
//   slave  : div_seq itself
// Signals
//   start/sgn/flr/x/y      request and operands (master -> slave)
//   ready/done/q/r/dbz/ovf status and results (slave -> master)
//   div_rst/div_x/div_y    launch pulse and magnitudes to div_int (slave -> master)
//   div_busy/div_q/div_r   div_int status and unsigned results (master -> slave)
// -----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int DSZ = 32
);
    logic           start;
    logic           sgn;
    logic           flr;
    logic [DSZ-1:0] x;
    logic [DSZ-1:0] y;
    logic           ready;
    logic           done;
    logic [DSZ-1:0] q;
    logic [DSZ-1:0] r;
    logic           dbz;
    logic           ovf;
    logic           div_rst;
    logic [DSZ-1:0] div_x;
    logic [DSZ-1:0] div_y;
    logic           div_busy;
    logic [DSZ-1:0] div_q;
    logic [DSZ-1:0] div_r;

    modport master (
        output start, sgn, flr, x, y, div_busy, div_q, div_r,
        input  ready, done, q, r, dbz, ovf, div_rst, div_x, div_y
    );

    modport slave (
        input  start, sgn, flr, x, y, div_busy, div_q, div_r,
        output ready, done, q, r, dbz, ovf, div_rst, div_x, div_y
    );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Division sequencer in front of div_int. Accepts one unsigned, signed
// symmetric (truncating) or signed floored divide, hands operand magnitudes to
// div_int, holds them while it iterates, then sign-corrects quotient and
// remainder. A zero divisor completes immediately without launching div_int.
// Ports
//   clk  clock
//   rst  synchronous active-high reset (aborts any operation, no done pulse)
//   io   div_seq_if.slave: request/result handshake and the div_int link
// Latency: done arrives DSZ+4 cycles after accept, or 1 cycle for y==0.
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int DSZ = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave io
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [DSZ-1:0]        MIN_NEG = {1'b1, {(DSZ-1){1'b0}}};
    localparam logic signed [DSZ-1:0] ONE     = DSZ'(1);

    state_t state;
    state_t state_nx;

    logic                  sgn_l;
    logic                  flr_l;
    logic                  xs;
    logic                  ys;
    logic [DSZ-1:0]        x_l;
    logic signed [DSZ-1:0] y_l;
    logic [DSZ-1:0]        qm;
    logic [DSZ-1:0]        rm;
    logic [DSZ-1:0]        q_reg;
    logic [DSZ-1:0]        r_reg;
    logic                  dbz_reg;
    logic                  ovf_reg;
    logic [DSZ-1:0]        dx;
    logic [DSZ-1:0]        dy;

    logic signed [DSZ-1:0] q_sym;
    logic signed [DSZ-1:0] r_sym;
    logic signed [DSZ-1:0] q_fix;
    logic signed [DSZ-1:0] r_fix;

    // Conditional two's-complement negation; -(100..0) wraps to itself.
    function automatic logic [DSZ-1:0] neg_if(input logic c, input logic [DSZ-1:0] v);
        return c ? (~v + DSZ'(1)) : v;
    endfunction

    // Floored result from the truncating one: only a non-zero remainder with
    // operands of opposite sign moves the quotient down and the remainder
    // across zero into the divisor's sign.
    function automatic logic need_floor(input logic f, input logic sx, input logic sy,
                                        input logic [DSZ-1:0] rmag);
        return f && (rmag != '0) && (sx != sy);
    endfunction

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---- next state ----
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io.start) state_nx = (io.y == '0) ? DONE : LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (!io.div_busy) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---- sign correction of the magnitude results ----
    always_comb begin
        q_sym = neg_if(xs ^ ys, qm);
        r_sym = neg_if(xs, rm);
        q_fix = q_sym;
        r_fix = r_sym;
        if (need_floor(flr_l, xs, ys, rm)) begin
            q_fix = q_sym - ONE;
            r_fix = r_sym + y_l;
        end
    end

    // ---- operand capture, div_int results, final results ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_l   <= 1'b0;
            flr_l   <= 1'b0;
            xs      <= 1'b0;
            ys      <= 1'b0;
            x_l     <= '0;
            y_l     <= '0;
            qm      <= '0;
            rm      <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
            ovf_reg <= 1'b0;
            dx      <= '0;
            dy      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        sgn_l   <= io.sgn;
                        flr_l   <= io.flr & io.sgn;
                        xs      <= io.sgn & io.x[DSZ-1];
                        ys      <= io.sgn & io.y[DSZ-1];
                        x_l     <= io.x;
                        y_l     <= io.y;
                        dx      <= neg_if(io.sgn & io.x[DSZ-1], io.x);
                        dy      <= neg_if(io.sgn & io.y[DSZ-1], io.y);
                        ovf_reg <= 1'b0;
                        dbz_reg <= (io.y == '0);
                        // Zero divisor finishes here; div_int never sees it.
                        if (io.y == '0) begin
                            q_reg <= '1;
                            r_reg <= io.x;
                        end
                    end
                end
                WAIT: begin
                    if (!io.div_busy) begin
                        qm <= io.div_q;
                        rm <= io.div_r;
                    end
                end
                FIX: begin
                    q_reg   <= q_fix;
                    r_reg   <= r_fix;
                    ovf_reg <= sgn_l && (x_l == MIN_NEG) && (y_l == '1);
                end
                default: ;
            endcase
        end
    end

    assign io.ready   = (state == IDLE);
    assign io.done    = (state == DONE);
    assign io.div_rst = (state == LAUNCH);
    assign io.div_x   = dx;
    assign io.div_y   = dy;
    assign io.q       = q_reg;
    assign io.r       = r_reg;
    assign io.dbz     = dbz_reg;
    assign io.ovf     = ovf_reg;

endmodule
